clk_rst_ctrl: RTL and testbench

Synthesisable clock-enable and reset sequencer for the block-level designs in this codebase, generalising the testbench-only clock/reset control to NUM_CH independent downstream domains. It synchronises the external asynchronous reset, releases per-channel resets in index order with programmable inter-channel delays, and generates per-channel divided clock-enable strobes. A software reset request re-runs the whole sequence.

---
 rtl/clk_rst_ctrl_pkg.sv | 22 ++
 rtl/rst_sync.sv | 23 ++
 rtl/clk_rst_ctrl.sv | 155 +++++++++++++++
 tb/tb_clk_rst_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/clk_rst_ctrl_pkg.sv
// Shared types and default sizing for the clock-enable / reset sequencer.
package clk_rst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEQ,
    ST_RUN,
    ST_HOLD
  } state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_HOLD_CYC    = 16;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after SYNC_STAGES clock edges.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  output logic rst_n_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign rst_n_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_rst_ctrl.sv
// Sequenced per-channel reset release with per-channel divided clock-enable strobes.
module clk_rst_ctrl
  import clk_rst_ctrl_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int HOLD_CYC    = DEF_HOLD_CYC
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    start,
  input  logic                    sw_rst_req,
  input  logic [NUM_CH*CNT_W-1:0] ch_delay,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic [NUM_CH-1:0]       ch_rst_n,
  output logic [NUM_CH-1:0]       ch_clk_en,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  logic rst_n;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .rst_n_o(rst_n)
  );

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    case (state_q)
      ST_IDLE: begin
        rst_d = '0;
        if (start) begin
          state_d = ST_SEQ;
          idx_d   = '0;
          cnt_d   = ch_delay[0 +: CNT_W];
        end
      end
      ST_SEQ: begin
        if (cnt_q == '0) begin
          rst_d[idx_q] = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = ch_delay[idx_d*CNT_W +: CNT_W];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        rst_d = '0;
        if (cnt_q == '0) begin
          state_d = ST_SEQ;
          idx_d   = '0;
          cnt_d   = ch_delay[0 +: CNT_W];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
    // Software reset overrides everything, including a coincident start.
    if (sw_rst_req) begin
      state_d = ST_HOLD;
      idx_d   = '0;
      rst_d   = '0;
      cnt_d   = CNT_W'(HOLD_CYC - 1);
    end
    busy_d = (state_d == ST_SEQ) || (state_d == ST_HOLD);
    done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Dividers key off the next reset value so enables drop on the same edge as the reset.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_div
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] dcnt_q, dcnt_d;
    logic             en_q, en_d;

    always_comb begin
      div_d  = div_q;
      dcnt_d = dcnt_q;
      en_d   = 1'b0;
      if (!rst_d[i]) begin
        div_d  = '0;
        dcnt_d = '0;
      end else if (!rst_q[i]) begin
        div_d  = ch_div[i*DIV_W +: DIV_W];
        dcnt_d = '0;
      end else if (dcnt_q == div_q) begin
        dcnt_d = '0;
        en_d   = 1'b1;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        div_q  <= '0;
        dcnt_q <= '0;
        en_q   <= 1'b0;
      end else begin
        div_q  <= div_d;
        dcnt_q <= dcnt_d;
        en_q   <= en_d;
      end
    end

    assign ch_clk_en[i] = en_q;
  end

  assign ch_rst_n = rst_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Directed bench for clk_rst_ctrl: reset release, sequencing, dividers, software reset, precedence.
`timescale 1ns/1ps
module tb_clk_rst_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int DIV_W  = 8;

  logic                    clk = 1'b0;
  logic                    arst_n;
  logic                    start;
  logic                    sw_rst_req;
  logic [NUM_CH*CNT_W-1:0] ch_delay;
  logic [NUM_CH*DIV_W-1:0] ch_div;
  logic [NUM_CH-1:0]       ch_rst_n;
  logic [NUM_CH-1:0]       ch_clk_en;
  logic                    busy;
  logic                    done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  clk_rst_ctrl #(
    .NUM_CH     (NUM_CH),
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .DIV_W      (DIV_W),
    .HOLD_CYC   (16)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (start),
    .sw_rst_req(sw_rst_req),
    .ch_delay  (ch_delay),
    .ch_div    (ch_div),
    .ch_rst_n  (ch_rst_n),
    .ch_clk_en (ch_clk_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_rst, input logic [3:0] e_en,
                           input logic e_busy, input logic e_done);
    check({tag, ".rst_n"}, 32'(ch_rst_n), 32'(e_rst));
    check({tag, ".clk_en"}, 32'(ch_clk_en), 32'(e_en));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    check({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  initial begin
    logic [3:0] e_rst;
    logic [3:0] e_en;

    arst_n     = 1'b0;
    start      = 1'b0;
    sw_rst_req = 1'b0;
    ch_delay   = {8'd5, 8'd1, 8'd3, 8'd0};
    ch_div     = {8'd3, 8'd1, 8'd0, 8'd2};

    #50;
    check_all("in_reset", 4'h0, 4'h0, 1'b0, 1'b0);
    #50;
    arst_n = 1'b1;

    // First edge after release: synchroniser not yet through, start held across the second edge.
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("start_during_sync", 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (5) step();
    check_all("idle_no_start", 4'h0, 4'h0, 1'b0, 1'b0);

    // Sequence: delays {0,3,1,5}, divs {2,0,1,3}; releases at E+1,E+5,E+7,E+13.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      start = (k == 3);
      if (k == 3) ch_div[0 +: DIV_W] = 8'd5;
      step();
      start = 1'b0;
      e_rst = (k >= 13) ? 4'b1111 : (k >= 7) ? 4'b0111 : (k >= 5) ? 4'b0011 : 4'b0001;
      e_en[0] = (k >= 4) && ((k - 1) % 3 == 0);
      e_en[1] = (k >= 6);
      e_en[2] = (k >= 9) && ((k - 7) % 2 == 0);
      e_en[3] = (k >= 17) && ((k - 13) % 4 == 0);
      check_all($sformatf("seq_k%0d", k), e_rst, e_en, k < 13, k >= 13);
    end

    // Software reset in RUN, then a second pulse at S+5 extends the restart to S+21.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    step();
    check_all("swrst_s1", 4'h0, 4'h0, 1'b1, 1'b0);
    repeat (3) step();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    repeat (12) step();
    check("swrst_s17.rst_n", 32'(ch_rst_n), 32'h0);
    repeat (4) step();
    check("swrst_s21.rst_n", 32'(ch_rst_n), 32'h0);
    check("swrst_s21.busy", 32'(busy), 32'h1);
    step();
    check("swrst_s22.rst_n", 32'(ch_rst_n), 32'h1);

    // Asynchronous reset mid-SEQ clears outputs before the next edge.
    repeat (2) step();
    #3;
    arst_n = 1'b0;
    #1;
    check_all("arst_mid_seq", 4'h0, 4'h0, 1'b0, 1'b0);
    #20;
    arst_n = 1'b1;
    repeat (30) step();
    check_all("idle_after_arst", 4'h0, 4'h0, 1'b0, 1'b0);

    // start and sw_rst_req together in IDLE: HOLD wins, ch0 releases at S+17.
    start      = 1'b1;
    sw_rst_req = 1'b1;
    step();
    start      = 1'b0;
    sw_rst_req = 1'b0;
    step();
    check_all("both_s1", 4'h0, 4'h0, 1'b1, 1'b0);
    repeat (15) step();
    check("both_s16.rst_n", 32'(ch_rst_n), 32'h0);
    step();
    check("both_s17.rst_n", 32'(ch_rst_n), 32'h1);
    check("both_s17.busy", 32'(busy), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
